multiplier: RTL and testbench
=============================

Name: multiplier

Overview:
- Sequential shift-add integer multiplier. Computes prod = a_in * b_in at full double width.
- Processes one multiplier bit per clock.
- Used as a shared arithmetic unit behind a valid/ready handshake. Trades latency (WIDTH cycles) for area versus a combinational array.

Parameters:
- WIDTH, 64, operand width in bits; product is 2*WIDTH bits; legal range 2..128.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands on a_in/b_in are valid.
- in_ready  output  1  block idle and able to accept operands.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- out_valid  output  1  prod holds a completed result.
- out_ready  input  1  consumer accepts the result.
- prod  output  2*WIDTH  product a_in*b_in, registered.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge) values:
  - in_ready=1, out_valid=0, prod=0.
  - Internal accumulator, operand and counter registers all 0.
  - State=IDLE.
  - Reset mid-computation aborts the operation; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a_in into the multiplicand register (zero-extended to 2*WIDTH) and b_in into the multiplier shift register; clear accumulator; load counter=WIDTH; go to BUSY.
  - in_valid=0: stay in IDLE.
- BUSY:
  - in_ready=0; a_in/b_in ignored.
  - Each edge: if multiplier LSB=1, accumulator += multiplicand. Then multiplicand shifts left 1, multiplier shifts right 1, counter decrements.
  - When counter reaches 0, copy accumulator to prod and go to DONE.
- DONE:
  - out_valid=1, in_ready=0; prod held stable.
  - On an edge with out_ready=1: clear out_valid and return to IDLE.
  - With out_ready=0: hold indefinitely.
- Latency: operands accepted at edge N give out_valid=1 after edge N+WIDTH (exactly WIDTH BUSY cycles). Latency is independent of operand values.
- Throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH compute, handshake).
- prod retains the last result after leaving DONE, until the next result overwrites it or reset clears it.
- Arithmetic rules:
  - Unsigned by default.
  - Full 2*WIDTH result; no truncation or overflow possible.
  - All-ones operands give (2^WIDTH-1)^2 exactly.
- in_valid asserted while not IDLE has no effect. The producer holds its operands until in_ready=1.
- Simultaneous out_ready and in_valid in DONE: only the result handshake completes. New operands are accepted no earlier than the following cycle in IDLE.
- in_valid during reset is ignored.

Optional Feature:
- Macro MULTIPLIER_SIGNED_EN.
- Defined:
  - a_in and b_in are two's complement; prod is the two's complement 2*WIDTH-bit signed product.
  - At accept, latch operand magnitudes and record sign = MSB(a_in) XOR MSB(b_in).
  - At completion, negate the accumulator if sign=1.
  - Most-negative operands are handled exactly (magnitude 2^(WIDTH-1) fits unsigned).
  - Latency is unchanged.
- Undefined: unsigned operation only; no sign logic synthesized.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, prod=0; no operation starts.
- Basic: a_in=200, b_in=1000, in_valid pulse -> out_valid rises exactly 64 cycles after accept; prod=200000; out_ready=1 returns to IDLE.
- Extremes: a_in=b_in=64'hFFFF_FFFF_FFFF_FFFF -> prod=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Also a_in=0, b_in=max -> prod=0.
- Backpressure: out_ready=0 for 20 cycles after result -> out_valid and prod held stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 at BUSY cycle 30 -> next cycle in_ready=1, out_valid=0, prod=0. A following op a=3, b=5 yields 15.
- Signed (MULTIPLIER_SIGNED_EN defined): a=-3 (all ones ...FD), b=7 -> prod=-21 sign-extended to 128 bits. a=b=64'h8000_0000_0000_0000 -> prod=2^126.

Source files
------------

// File: rtl/multiplier.sv
// multiplier: sequential shift-add multiplier, one multiplier bit per clock; define MULTIPLIER_SIGNED_EN for two's complement operands
module multiplier #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_nxt;
   logic [2*WIDTH-1:0]  mcand, acc, acc_nxt, result;
   logic [WIDTH-1:0]    mplier, a_mag, b_mag;
   logic [CW-1:0]       cnt;
   logic                last, accept;

   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   assign last    = cnt == CW'(1);
   assign accept  = state == IDLE && in_valid;

`ifdef MULTIPLIER_SIGNED_EN
   logic sign;
   assign a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
   assign b_mag  = b_in[WIDTH-1] ? -b_in : b_in;
   assign result = sign ? -acc_nxt : acc_nxt;
`else
   assign a_mag  = a_in;
   assign b_mag  = b_in;
   assign result = acc_nxt;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_valid  ? BUSY : IDLE;
         BUSY:    state_nxt = last      ? DONE : BUSY;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end

   // operand load, shift-add iteration and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         prod   <= '0;
`ifdef MULTIPLIER_SIGNED_EN
         sign   <= 1'b0;
`endif
      end else if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         mplier <= b_mag;
         acc    <= '0;
         cnt    <= CW'(WIDTH);
`ifdef MULTIPLIER_SIGNED_EN
         sign   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
      end else if (state == BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (last) prod <= result;
      end
   end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: directed and random checks of the shift-add multiplier against a plain arithmetic model
module tb_multiplier;
   localparam int W = 64;

   logic           clk = 0;
   logic           rst_n = 0;
   logic           in_valid = 0;
   logic           in_ready;
   logic [W-1:0]   a_in = '0;
   logic [W-1:0]   b_in = '0;
   logic           out_valid;
   logic           out_ready = 0;
   logic [2*W-1:0] prod;

   int total = 0;
   int passed = 0;
   int failed = 0;

   multiplier #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .prod(prod)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTIPLIER_SIGNED_EN
      logic signed [2*W-1:0] sa, sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
`else
      logic [2*W-1:0] ua, ub;
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      return ua * ub;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      check({tag, "_idle_ready"}, in_ready, 1);
      in_valid = 1;
      a_in = a;
      b_in = b;
      tick();
      in_valid = 0;
      check({tag, "_busy_not_ready"}, in_ready, 0);
   endtask

   task automatic finish_op(input string tag, input logic [2*W-1:0] exp);
      int cyc = 0;
      while (out_valid !== 1'b1 && cyc < W + 10) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, W);
      check({tag, "_prod"}, prod, exp);
      check({tag, "_done_not_ready"}, in_ready, 0);
   endtask

   task automatic handshake(input string tag, input logic [2*W-1:0] exp);
      out_ready = 1;
      tick();
      out_ready = 0;
      check({tag, "_valid_cleared"}, out_valid, 0);
      check({tag, "_back_idle"}, in_ready, 1);
      check({tag, "_prod_retained"}, prod, exp);
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      start(tag, a, b);
      finish_op(tag, model(a, b));
      handshake(tag, model(a, b));
   endtask

   initial begin
      logic [W-1:0]   ra, rb;
      logic [2*W-1:0] exp;
      // reset held with in_valid asserted
      in_valid = 1;
      a_in = 64'd12;
      b_in = 64'd34;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_prod", prod, 0);
      in_valid = 0;
      rst_n = 1;
      repeat (W + 4) tick();
      check("rst_no_op_valid", out_valid, 0);
      check("rst_no_op_prod", prod, 0);
      // basic and extremes
      full_op("basic", 64'd200, 64'd1000);
`ifndef MULTIPLIER_SIGNED_EN
      check("basic_literal", prod, 128'd200000);
`endif
      full_op("all_ones", '1, '1);
`ifndef MULTIPLIER_SIGNED_EN
      check("all_ones_literal", prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
`endif
      full_op("zero_a", '0, '1);
      // backpressure with in_valid ignored while not idle
      start("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
      exp = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
      finish_op("bp", exp);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1;
         a_in = {$urandom, $urandom};
         b_in = {$urandom, $urandom};
         tick();
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_prod", prod, exp);
         check("bp_hold_not_ready", in_ready, 0);
      end
      a_in = 64'd9;
      b_in = 64'd11;
      out_ready = 1;
      tick();
      out_ready = 0;
      check("bp_release_idle", in_ready, 1);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_prod", prod, exp);
      tick();
      in_valid = 0;
      check("bp_next_accept", in_ready, 0);
      finish_op("bp_next", model(64'd9, 64'd11));
      handshake("bp_next", model(64'd9, 64'd11));
      // reset in the middle of a computation
      start("midrst", 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF);
      repeat (29) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_prod", prod, 0);
      repeat (W + 4) tick();
      check("midrst_no_result", out_valid, 0);
      full_op("after_rst", 64'd3, 64'd5);
`ifndef MULTIPLIER_SIGNED_EN
      check("after_rst_literal", prod, 128'd15);
`endif
`ifdef MULTIPLIER_SIGNED_EN
      full_op("s_neg3x7", -64'sd3, 64'd7);
      check("s_neg3x7_literal", prod, -128'sd21);
      full_op("s_minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check("s_minxmin_literal", prod, 128'd1 << 126);
      full_op("s_minx1", 64'h8000_0000_0000_0000, 64'd1);
`endif
      // random operands with random consumer delay
      for (int i = 0; i < 12; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i == 0) ra = ra >> 40;
         if (i == 1) rb = rb >> 50;
         exp = model(ra, rb);
         start("rand", ra, rb);
         finish_op("rand", exp);
         repeat ($urandom_range(0, 3)) begin
            tick();
            check("rand_hold_prod", prod, exp);
         end
         handshake("rand", exp);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
